muldiv_hilo: RTL

Multi-cycle 32-bit multiply/divide unit with HI/LO registers. It sits beside the 32-bit ALU in the execute stage and consumes the same 6-bit function code (`Signal`). It performs MULTU/DIVU iteratively and returns HI or LO on MFHI/MFLO. The execute-stage result mux selects between its `dataOut` and the ALU result.

---
 rtl/muldiv_hilo.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo.sv
// Iterative 32-cycle MULTU/DIVU unit with HI/LO result registers and an MFHI/MFLO read port.
// Define MULDIV_SIGNED_EN to also accept MULT/DIV (magnitude core plus a sign fix-up on commit).
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [5:0]       Signal,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_DIVU  = 6'd27;
    localparam logic [5:0] OP_MFHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd18;
`ifdef MULDIV_SIGNED_EN
    localparam logic [5:0] OP_MULT  = 6'd24;
    localparam logic [5:0] OP_DIV   = 6'd26;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             is_div;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             op_ok, op_div, accept;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_trial;

`ifdef MULDIV_SIGNED_EN
    logic sgn_op;
    logic neg_q, neg_r;

    assign sgn_op = (Signal == OP_MULT) || (Signal == OP_DIV);
    assign op_ok  = (Signal == OP_MULTU) || (Signal == OP_DIVU) || sgn_op;
    assign op_div = (Signal == OP_DIVU) || (Signal == OP_DIV);
    assign a_mag  = (sgn_op && dataA[WIDTH-1]) ? -dataA : dataA;
    assign b_mag  = (sgn_op && dataB[WIDTH-1]) ? -dataB : dataB;
`else
    assign op_ok  = (Signal == OP_MULTU) || (Signal == OP_DIVU);
    assign op_div = (Signal == OP_DIVU);
    assign a_mag  = dataA;
    assign b_mag  = dataB;
`endif

    assign accept = start && (state == S_IDLE) && op_ok;

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: if (accept) state_nxt = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (cnt == CNT_LAST) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Multiply: {acc_hi,acc_lo} is the product, opnd the multiplicand.
    // Divide:   acc_hi is the remainder, acc_lo the quotient, opnd the divisor.
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    assign div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd};

    always_comb begin
        res_hi = acc_hi;
        res_lo = acc_lo;
`ifdef MULDIV_SIGNED_EN
        if (!is_div) begin
            if (neg_q) {res_hi, res_lo} = -{acc_hi, acc_lo};
        end else begin
            if (neg_q) res_lo = -acc_lo;
            if (neg_r) res_hi = -acc_hi;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef MULDIV_SIGNED_EN
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    cnt    <= '0;
                    acc_hi <= '0;
                    is_div <= op_div;
                    acc_lo <= op_div ? a_mag : b_mag;
                    opnd   <= op_div ? b_mag : a_mag;
`ifdef MULDIV_SIGNED_EN
                    // A zero divisor keeps the all-ones quotient regardless of signs.
                    neg_q  <= sgn_op && (dataA[WIDTH-1] ^ dataB[WIDTH-1]) &&
                              !(op_div && (dataB == '0));
                    neg_r  <= sgn_op && op_div && dataA[WIDTH-1];
`endif
                end
                S_RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        acc_hi <= div_trial[WIDTH] ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]}
                                                   : div_trial[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                S_DONE: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dataOut = '0;
        if (Signal == OP_MFHI)      dataOut = hi;
        else if (Signal == OP_MFLO) dataOut = lo;
    end

endmodule
